// File: rtl/rv32i_dbus_responder.sv
// Data-bus responder for the memory-stage load/store initiator.
// Serves word requests from a local RAM or an MMIO window after a fixed wait-state delay.
module rv32i_dbus_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter logic [15:0] MMIO_BASE_HI = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  led_out
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned OFF_W     = 14;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [OFF_W-1:0] OFF_CYCLE   = 14'h0000;
  localparam logic [OFF_W-1:0] OFF_SCRATCH = 14'h0001;
  localparam logic [OFF_W-1:0] OFF_LED     = 14'h0002;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic             r_mmio;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_off;
  logic [31:0]      r_cyc_snap;
  logic [31:0]      r_cycle;
  logic [31:0]      r_scratch;
  logic [7:0]       r_led;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_req_mmio;
  logic [IDX_W-1:0] w_req_idx;
  logic [OFF_W-1:0] w_req_off;
  logic             w_sel_we;
  logic             w_sel_mmio;
  logic [IDX_W-1:0] w_sel_idx;
  logic [OFF_W-1:0] w_sel_off;
  logic [31:0]      w_sel_cyc;
  logic [31:0]      w_rd_data;
  logic             w_rd_err;
  logic             w_unused_addr;

  assign w_unused_addr = ^req_addr[1:0];

  assign w_accept   = reset && (r_state == S_IDLE) && req_valid;
  assign w_req_mmio = (req_addr[31:16] == MMIO_BASE_HI);
  assign w_req_idx  = req_addr[IDX_W+1:2];
  assign w_req_off  = req_addr[15:2];

  // With zero wait states the response is built in the acceptance cycle, so bypass the capture regs.
  assign w_sel_we   = (r_state == S_IDLE) ? req_we     : r_we;
  assign w_sel_mmio = (r_state == S_IDLE) ? w_req_mmio : r_mmio;
  assign w_sel_idx  = (r_state == S_IDLE) ? w_req_idx  : r_idx;
  assign w_sel_off  = (r_state == S_IDLE) ? w_req_off  : r_off;
  assign w_sel_cyc  = (r_state == S_IDLE) ? r_cycle    : r_cyc_snap;

  assign led_out = r_led;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Response data / error decode
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_sel_mmio) begin
      case (w_sel_off)
        OFF_CYCLE:   w_rd_data = w_sel_cyc;
        OFF_SCRATCH: w_rd_data = r_scratch;
        OFF_LED:     w_rd_data = {24'b0, r_led};
        default:     w_rd_err  = 1'b1;
      endcase
    end else begin
      w_rd_data = r_mem[w_sel_idx];
    end
    if (w_sel_we) w_rd_data = '0;
  end

  // Handshake outputs, request capture, wait counter and MMIO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_mmio     <= 1'b0;
      r_idx      <= '0;
      r_off      <= '0;
      r_cyc_snap <= '0;
      r_cycle    <= '0;
      r_scratch  <= '0;
      r_led      <= '0;
    end else begin
      r_cycle   <= r_cycle + 32'd1;
      req_ready <= (w_next == S_IDLE);
      rsp_valid <= (w_next == S_RESP);
      rsp_rdata <= (w_next == S_RESP) ? w_rd_data : '0;
      rsp_err   <= (w_next == S_RESP) ? w_rd_err  : 1'b0;
      if (w_accept) begin
        r_cnt      <= CNT_W'(WAIT_LOAD);
        r_we       <= req_we;
        r_mmio     <= w_req_mmio;
        r_idx      <= w_req_idx;
        r_off      <= w_req_off;
        r_cyc_snap <= r_cycle;
        if (w_req_mmio && req_we) begin
          if (w_req_off == OFF_SCRATCH) begin
            for (int i = 0; i < 4; i++) begin
              if (req_be[i]) r_scratch[8*i +: 8] <= req_wdata[8*i +: 8];
            end
          end
          if (w_req_off == OFF_LED && req_be[0]) r_led <= req_wdata[7:0];
        end
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // RAM store lanes commit at the acceptance edge; contents survive reset
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_req_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) r_mem[w_req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32i_dbus_responder.sv
// Directed bench for rv32i_dbus_responder: three instances with 1, 0 and 5 wait states.
module tb_rv32i_dbus_responder;

  logic        clk;
  logic        rst_n [3];
  logic        valid [3];
  logic        ready [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [3:0]  be    [3];
  logic [31:0] wdata [3];
  logic        rspv  [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic [7:0]  led   [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] cap  [14];
  logic [13:0] rpat;
  logic [13:0] vpat;
  logic        seen;

  rv32i_dbus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .MMIO_BASE_HI(16'hFFFF)) dut0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(valid[0]), .req_ready(ready[0]), .req_we(we[0]),
    .req_addr(addr[0]), .req_be(be[0]), .req_wdata(wdata[0]), .rsp_valid(rspv[0]),
    .rsp_rdata(rdata[0]), .rsp_err(err[0]), .led_out(led[0]));

  rv32i_dbus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .MMIO_BASE_HI(16'hFFFF)) dut1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(valid[1]), .req_ready(ready[1]), .req_we(we[1]),
    .req_addr(addr[1]), .req_be(be[1]), .req_wdata(wdata[1]), .rsp_valid(rspv[1]),
    .rsp_rdata(rdata[1]), .rsp_err(err[1]), .led_out(led[1]));

  rv32i_dbus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(5), .MMIO_BASE_HI(16'hFFFF)) dut2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(valid[2]), .req_ready(ready[2]), .req_we(we[2]),
    .req_addr(addr[2]), .req_be(be[2]), .req_wdata(wdata[2]), .rsp_valid(rspv[2]),
    .rsp_rdata(rdata[2]), .rsp_err(err[2]), .led_out(led[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after its acceptance edge.
  task automatic accept_only(input int d, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready[d]), 32'd1);
    valid[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  // Full transaction with latency, data, error and handshake checks.
  task automatic run(input string tag, input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat);
    int lat;
    accept_only(d, w, a, b, wd);
    chk({tag, "_busy"}, 32'(ready[d]), 32'd0);
    lat = 1;
    while (!rspv[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"},   32'(lat),    32'(exp_lat));
    chk({tag, "_rdata"}, rdata[d],    exp_rd);
    chk({tag, "_err"},   32'(err[d]), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rspv[d]),  32'd0);
    chk({tag, "_ready"}, 32'(ready[d]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; valid[i] = 1'b0; we[i] = 1'b0;
      addr[i] = '0; be[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready[0]), 32'd1);
    chk("rst_rspv",  32'(rspv[0]),  32'd0);
    chk("rst_rdata", rdata[0],      32'd0);
    chk("rst_err",   32'(err[0]),   32'd0);
    chk("rst_led",   32'(led[0]),   32'd0);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // One wait state: store/load, byte lanes, aliasing
    run("st_full",  0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    run("ld_full",  0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0, 2);
    run("st_lane",  0, 1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344, 32'h0, 1'b0, 2);
    run("ld_lane",  0, 1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDE22_BE44, 1'b0, 2);
    run("st_alias", 0, 1'b1, 32'h0000_1010, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0, 2);
    run("ld_alias", 0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hA5A5_A5A5, 1'b0, 2);
    run("st_be0",   0, 1'b1, 32'h0000_0010, 4'h0, 32'h0BAD_0BAD, 32'h0, 1'b0, 2);
    run("ld_be0",   0, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hA5A5_A5A5, 1'b0, 2);

    // MMIO window
    run("st_led",   0, 1'b1, 32'hFFFF_0008, 4'hF, 32'h0000_01FF, 32'h0, 1'b0, 2);
    chk("led_out",  32'(led[0]), 32'h0000_00FF);
    run("ld_led",   0, 1'b0, 32'hFFFF_0008, 4'h0, 32'h0,         32'h0000_00FF, 1'b0, 2);
    run("ld_bad",   0, 1'b0, 32'hFFFF_000C, 4'h0, 32'h0,         32'h0, 1'b1, 2);
    run("st_bad",   0, 1'b1, 32'hFFFF_0010, 4'hF, 32'h1234_5678, 32'h0, 1'b1, 2);
    run("st_scr",   0, 1'b1, 32'hFFFF_0004, 4'b1100, 32'h1234_5678, 32'h0, 1'b0, 2);
    run("ld_scr",   0, 1'b0, 32'hFFFF_0004, 4'h0, 32'h0,         32'h1234_0000, 1'b0, 2);
    run("st_cyc",   0, 1'b1, 32'hFFFF_0000, 4'hF, 32'h0,         32'h0, 1'b0, 2);

    // Zero wait states
    run("w0_st",    1, 1'b1, 32'h0000_0020, 4'hF, 32'h0000_0077, 32'h0, 1'b0, 1);
    run("w0_ld",    1, 1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h0000_0077, 1'b0, 1);

    // Held request on W=0: back-to-back CYCLE loads two cycles apart
    @(negedge clk);
    valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'hFFFF_0000; be[1] = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rpat[i] = ready[1];
      vpat[i] = rspv[1];
      cap[i]  = rdata[1];
    end
    valid[1] = 1'b0;
    chk("w0_hold_ready", 32'(rpat[5:0]), 32'h0000_002A);
    chk("w0_hold_rspv",  32'(vpat[5:0]), 32'h0000_0015);
    chk("w0_cyc_diff",   cap[2] - cap[0], 32'd2);
    chk("w0_cyc_diff2",  cap[4] - cap[2], 32'd2);

    // Five wait states: latency, then a held request observed across two transactions
    run("w5_st",    2, 1'b1, 32'h0000_0030, 4'hF, 32'h0C0F_FEE0, 32'h0, 1'b0, 6);
    run("w5_ld",    2, 1'b0, 32'h0000_0030, 4'h0, 32'h0,         32'h0C0F_FEE0, 1'b0, 6);
    @(negedge clk);
    valid[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'hFFFF_0000; be[2] = 4'h0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rpat[i] = ready[2];
      vpat[i] = rspv[2];
      cap[i]  = rdata[2];
    end
    valid[2] = 1'b0;
    chk("w5_hold_ready", 32'(rpat), 32'h0000_2040);
    chk("w5_hold_rspv",  32'(vpat), 32'h0000_1020);
    chk("w5_cyc_diff",   cap[12] - cap[5], 32'd7);

    // Async reset during WAIT: first with a store pending, then with a load pending
    run("w5_st_led", 2, 1'b1, 32'hFFFF_0008, 4'h1, 32'h0000_005A, 32'h0, 1'b0, 6);
    chk("w5_led",    32'(led[2]), 32'h0000_005A);
    accept_only(2, 1'b1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("rst_st_ready", 32'(ready[2]), 32'd1);
    chk("rst_st_led",   32'(led[2]),   32'd0);
    chk("rst_st_rspv",  32'(rspv[2]),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= rspv[2];
      if (i == 2) rst_n[2] = 1'b1;
    end
    chk("rst_st_norsp", 32'(seen), 32'd0);

    accept_only(2, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("rst_ld_ready", 32'(ready[2]), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= rspv[2];
      if (i == 2) rst_n[2] = 1'b1;
    end
    chk("rst_ld_norsp", 32'(seen), 32'd0);
    chk("rst_ld_led",   32'(led[2]), 32'd0);
    run("rst_keep",  2, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
